multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 150 +++++++++++++++
 tb/tb_multicycle_control.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: LEGv8 multicycle control FSM; define PERF_CNT_EN to add saturating cycle/instr counters
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif
module multicycle_control (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [`INSTR_LEN-1:0] instruction,
  input  logic                  zero,
  input  logic                  mem_ack,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  IorD,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic [1:0]            pc_src,
  output logic                  Reg2Loc,
  output logic                  ALUSrc,
  output logic                  MemtoReg,
  output logic                  RegWrite,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [1:0]            ALUOp,
  output logic [2:0]            state,
  output logic                  instr_done,
  output logic                  trap,
  output logic [31:0]           cycle_cnt,
  output logic [31:0]           instr_cnt
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} st_t;
  typedef enum logic [2:0] {C_LDUR, C_STUR, C_R, C_CBZ, C_B, C_ILL} cls_t;
  st_t cur, nxt;
  cls_t cls, dcls;
  logic unused_ir;
  assign unused_ir = ^instruction;
  assign state = cur;
  // classify the IR contents; only meaningful while in DECODE
  always_comb begin
    dcls = C_ILL;
    if (instruction[31:21] == 11'h7C2) dcls = C_LDUR;
    else if (instruction[31:21] == 11'h7C0) dcls = C_STUR;
    else if (instruction[31:21] inside {11'h458, 11'h658, 11'h450, 11'h550}) dcls = C_R;
    else if (instruction[31:24] == 8'hB4) dcls = C_CBZ;
    else if (instruction[31:26] == 6'h05) dcls = C_B;
  end
  // state register and class latch; reset discards the latched class
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cur <= FETCH;
      cls <= C_ILL;
    end else begin
      cur <= nxt;
      if (cur == DECODE) cls <= dcls;
    end
  // next state and outputs; everything is forced low while reset_n is low
  always_comb begin
    nxt = cur;
    mem_req = 1'b0;
    mem_we = 1'b0;
    IorD = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_src = 2'd0;
    Reg2Loc = 1'b0;
    ALUSrc = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    ALUOp = 2'b00;
    instr_done = 1'b0;
    trap = 1'b0;
    if (reset_n)
      case (cur)
        FETCH: begin
          mem_req = 1'b1;
          MemRead = 1'b1;
          ir_write = mem_ack;
          pc_write = mem_ack;
          if (mem_ack) nxt = DECODE;
        end
        DECODE: begin
          Reg2Loc = dcls inside {C_STUR, C_CBZ};
          if (dcls == C_ILL) nxt = TRAP;
          else nxt = EXEC;
        end
        EXEC: begin
          Reg2Loc = cls inside {C_STUR, C_CBZ};
          case (cls)
            C_R: begin
              ALUOp = 2'b10;
              nxt = WB;
            end
            C_LDUR, C_STUR: begin
              ALUSrc = 1'b1;
              nxt = MEM;
            end
            C_CBZ: begin
              ALUOp = 2'b01;
              pc_write = zero;
              pc_src = 2'd1;
              instr_done = 1'b1;
              nxt = FETCH;
            end
            C_B: begin
              pc_write = 1'b1;
              pc_src = 2'd2;
              instr_done = 1'b1;
              nxt = FETCH;
            end
            default: nxt = TRAP;
          endcase
        end
        MEM: begin
          mem_req = 1'b1;
          IorD = 1'b1;
          MemRead = cls == C_LDUR;
          MemWrite = cls == C_STUR;
          mem_we = cls == C_STUR;
          instr_done = mem_ack && cls == C_STUR;
          if (mem_ack && cls == C_LDUR) nxt = WB;
          else if (mem_ack) nxt = FETCH;
        end
        WB: begin
          RegWrite = 1'b1;
          MemtoReg = cls == C_LDUR;
          instr_done = 1'b1;
          nxt = FETCH;
        end
        default: trap = 1'b1;
      endcase
  end
`ifdef PERF_CNT_EN
  logic [31:0] cyc, ins;
  // saturating counters; cycles stop counting once trapped
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cyc <= '0;
      ins <= '0;
    end else begin
      if (cur != TRAP && cyc != '1) cyc <= cyc + 32'd1;
      if (instr_done && ins != '1) ins <= ins + 32'd1;
    end
  assign cycle_cnt = cyc;
  assign instr_cnt = ins;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized trace-model bench for multicycle_control
module tb_multicycle_control;
`ifdef PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam int LD = 0, ST = 1, R = 2, CBZ = 3, B = 4, ILL = 5;
  typedef struct packed {
    logic [2:0] st;
    logic req, we, iord, irw, pcw;
    logic [1:0] psrc;
    logic r2l, alus, m2r, rw, mr, mw;
    logic [1:0] aop;
    logic done, trap;
  } vec_t;
  typedef struct {
    logic [31:0] ins;
    logic z, ack;
    vec_t exp;
  } ent_t;
  logic clk = 1'b0, reset_n, zero, mem_ack;
  logic [31:0] instruction;
  logic mem_req, mem_we, IorD, ir_write, pc_write, Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, instr_done, trap;
  logic [1:0] pc_src, ALUOp;
  logic [2:0] state;
  logic [31:0] cycle_cnt, instr_cnt;
  vec_t dv, e;
  logic chk = 1'b0;
  int tests = 0, fails = 0;
  int m_cyc = 0, m_ins = 0, e_cyc = 0, e_ins = 0;
  ent_t q[$];
  multicycle_control dut (
    .clk(clk), .reset_n(reset_n), .instruction(instruction), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .IorD(IorD), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .ALUOp(ALUOp), .state(state), .instr_done(instr_done),
    .trap(trap), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );
  assign dv = {state, mem_req, mem_we, IorD, ir_write, pc_write, pc_src, Reg2Loc, ALUSrc,
               MemtoReg, RegWrite, MemRead, MemWrite, ALUOp, instr_done, trap};
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] x);
    tests++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, a, x);
    end
  endtask
  always @(negedge clk)
    if (chk) begin
      check("outputs", 32'(dv), 32'(e));
      check("cycle_cnt", cycle_cnt, PERF ? e_cyc : 0);
      check("instr_cnt", instr_cnt, PERF ? e_ins : 0);
    end
  function automatic logic [31:0] enc(input int c);
    logic [10:0] rop[4] = '{11'h458, 11'h658, 11'h450, 11'h550};
    logic [31:0] r = $urandom;
    case (c)
      LD: return {11'h7C2, r[20:0]};
      ST: return {11'h7C0, r[20:0]};
      R: return {rop[$urandom % 4], r[20:0]};
      CBZ: return {8'hB4, r[23:0]};
      default: return {6'h05, r[25:0]};
    endcase
  endfunction
  task automatic push(input ent_t t, input vec_t v);
    t.exp = v;
    q.push_back(t);
  endtask
  task automatic gen(input int c, input logic [31:0] ins, input int n1, input int n2, input logic z);
    ent_t t;
    vec_t v;
    t.ins = ins;
    t.z = z;
    for (int i = 1; i <= n1; i++) begin
      v = '0; v.req = 1; v.mr = 1;
      t.ack = (i == n1); v.irw = t.ack; v.pcw = t.ack;
      push(t, v);
    end
    v = '0; v.st = 1; v.r2l = (c == ST || c == CBZ); t.ack = 1'($urandom % 2);
    push(t, v);
    if (c == ILL) begin
      for (int i = 0; i < n2; i++) begin
        v = '0; v.st = 5; v.trap = 1; t.ack = 1'($urandom % 2);
        push(t, v);
      end
      return;
    end
    v = '0; v.st = 2; v.r2l = (c == ST || c == CBZ); t.ack = 1'($urandom % 2);
    if (c == R) v.aop = 2;
    if (c == LD || c == ST) v.alus = 1;
    if (c == CBZ) begin v.aop = 1; v.pcw = z; v.psrc = 1; v.done = 1; end
    if (c == B) begin v.pcw = 1; v.psrc = 2; v.done = 1; end
    push(t, v);
    if (c == LD || c == ST)
      for (int i = 1; i <= n2; i++) begin
        v = '0; v.st = 3; v.req = 1; v.iord = 1;
        v.mr = (c == LD); v.mw = (c == ST); v.we = (c == ST);
        t.ack = (i == n2); v.done = t.ack && c == ST;
        push(t, v);
      end
    if (c == R || c == LD) begin
      v = '0; v.st = 4; v.rw = 1; v.m2r = (c == LD); v.done = 1; t.ack = 1'($urandom % 2);
      push(t, v);
    end
  endtask
  task automatic play(input int upto);
    int n = (upto < 0) ? q.size() : upto;
    for (int i = 0; i < n; i++) begin
      instruction = q[i].ins; zero = q[i].z; mem_ack = q[i].ack;
      e = q[i].exp; e_cyc = m_cyc; e_ins = m_ins; chk = 1;
      @(posedge clk); #1;
      chk = 0;
      if (q[i].exp.st != 3'd5) m_cyc++;
      if (q[i].exp.done) m_ins++;
    end
    q.delete();
  endtask
  task automatic do_reset();
    chk = 0; mem_ack = 0; reset_n = 0;
    @(posedge clk); #1;
    reset_n = 1; m_cyc = 0; m_ins = 0;
    #1 check("restart_fetch", 32'({state, mem_req}), 32'h1);
  endtask
  initial begin
    int c, c0;
    reset_n = 0; instruction = 0; zero = 0; mem_ack = 1;
    repeat (2) @(posedge clk);
    #1 check("reset_outputs", 32'(dv), 0);
    check("reset_cycle_cnt", cycle_cnt, 0);
    check("reset_instr_cnt", instr_cnt, 0);
    mem_ack = 0;
    reset_n = 1;
    #1 check("first_fetch", 32'({state, mem_req}), 32'h1);
    gen(LD, 32'hF84402C9, 1, 1, 0);
    check("ldur_len", q.size(), 5);
    check("ldur_states", 32'({q[0].exp.st, q[1].exp.st, q[2].exp.st, q[3].exp.st, q[4].exp.st}), 32'o01234);
    check("ldur_wb", 32'({q[4].exp.rw, q[4].exp.m2r, q[4].exp.done, q[3].exp.done}), 32'hE);
    play(-1);
    check("ldur_instr_cnt", instr_cnt, PERF ? 1 : 0);
    check("ldur_cycle_cnt", cycle_cnt, PERF ? 5 : 0);
    do_reset();
    gen(R, 32'h8B09026A, 2, 0, 0);
    check("add_len", q.size(), 5);
    check("add_exec", 32'({q[3].exp.st, q[3].exp.aop, q[3].exp.alus}), 32'b010100);
    gen(R, 32'hAA150149, 1, 0, 1);
    play(-1);
    check("add_orr_instr_cnt", instr_cnt, PERF ? 2 : 0);
    gen(ST, 32'hF80602CB, 1, 3, 0);
    check("stur_len", q.size(), 6);
    check("stur_mem", 32'({q[3].exp.req, q[3].exp.we, q[3].exp.mw, q[3].exp.iord, q[5].exp.done, q[5].exp.rw}), 32'b111110);
    play(-1);
    gen(CBZ, 32'hB4FFFF6B, 1, 0, 1);
    check("cbz_len", q.size(), 3);
    check("cbz_taken", 32'({q[2].exp.pcw, q[2].exp.psrc, q[2].exp.aop}), 32'b10101);
    gen(CBZ, 32'hB4FFFF6B, 2, 0, 0);
    gen(B, 32'h17FFFFC9, 3, 0, 0);
    play(-1);
    for (int k = 0; k < 150; k++) begin
      c = $urandom_range(0, 4);
      gen(c, enc(c), $urandom_range(1, 4), $urandom_range(1, 4), 1'($urandom % 2));
      play(-1);
    end
    gen(ST, 32'hF80602CB, 1, 6, 0);
    play(5);
    #1 reset_n = 0;
    #1 check("async_drop_req", 32'(mem_req), 0);
    check("async_outputs", 32'(dv), 0);
    check("async_cycle_cnt", cycle_cnt, 0);
    check("async_instr_cnt", instr_cnt, 0);
    do_reset();
    gen(LD, enc(LD), 2, 3, 0);
    play(-1);
    check("post_reset_instr_cnt", instr_cnt, PERF ? 1 : 0);
    gen(ILL, 32'h00000000, 2, 20, 0);
    play(-1);
    c0 = m_cyc;
    repeat (3) @(posedge clk);
    #1 check("trap_hold", 32'({state, trap, mem_req}), 32'b10110);
    check("trap_cycle_frozen", cycle_cnt, PERF ? c0 : 0);
    do_reset();
    gen(ILL, 32'hFFFFFFFF, 1, 3, 0);
    play(-1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
